// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  // Operation encodings as presented on op_i.
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } mdu_state_e;

  // Quotient reported for a division by zero.
  localparam logic [MDU_WIDTH-1:0] DIVZERO_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: out_val = neg ? -in_val : in_val.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its inputs).
//   neg     in  1  negate when high
//   in_val  in  W  value to fix up
//   out_val out W  result
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] in_val,
  output logic [W-1:0] out_val
);

  assign out_val = neg ? (W'(0) - in_val) : in_val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Latency: accept on edge 1, HI/LO and done_o update on edge 34; next accept on edge 35.
// Backpressure: stall_o holds the front of the pipe while busy; start_i while busy is ignored.
//   clk_i, rst_i (async active-low)          clock and reset
//   start_i, op_i, rs_data_i, rt_data_i      operation launch and operands
//   flush_i                                  abort current op / block launch
//   hi_we_i, lo_we_i, wdata_i                MTHI/MTLO writes (honoured only when idle)
//   hi_o, lo_o, busy_o, done_o, stall_o      results and status
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o
);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  // Multiply: {partial_hi, multiplier shifting out}. Divide: {rem, quot}.
  logic [2*WIDTH-1:0] work_q;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  // ---------------- operand decode ----------------
  mdu_op_e          op;
  logic             signed_op, div_op, launch;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] mag_rs, mag_rt;

  assign op        = mdu_op_e'(op_i);
  assign signed_op = op_is_signed(op);
  assign div_op    = op_is_div(op);
  assign rs_neg    = signed_op & rs_data_i[WIDTH-1];
  assign rt_neg    = signed_op & rt_data_i[WIDTH-1];
  assign launch    = start_i & ~flush_i;

  mdu_sign_fix #(.W(WIDTH)) u_mag_rs (.neg(rs_neg), .in_val(rs_data_i), .out_val(mag_rs));
  mdu_sign_fix #(.W(WIDTH)) u_mag_rt (.neg(rt_neg), .in_val(rt_data_i), .out_val(mag_rt));

  // ---------------- one iteration step ----------------
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic               div_ok;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] work_step;

  // Shift-add: add multiplicand into the upper half when the outgoing
  // multiplier bit is set, then shift the whole product right by one.
  assign mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} +
                   {1'b0, (work_q[0] ? opnd_q : {WIDTH{1'b0}})};

  // Restoring step: the shifted remainder needs WIDTH+1 bits. When the
  // subtraction succeeds the difference is below the divisor, so the low
  // WIDTH bits of a modulo-2^WIDTH subtract are exact.
  assign div_trial = work_q[2*WIDTH-1:WIDTH-1];
  assign div_ok    = (div_trial >= {1'b0, opnd_q});
  assign div_sub   = div_trial[WIDTH-1:0] - opnd_q;

  always_comb begin
    work_step = {mul_sum, work_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (div_ok) work_step = {div_sub, work_q[WIDTH-2:0], 1'b1};
      else        work_step = {work_q[2*WIDTH-2:0], 1'b0};
    end
  end

  // ---------------- sign fix-up of results ----------------
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed, rem_fixed;

  mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.neg(neg_res_q), .in_val(work_q), .out_val(prod_fixed));
  mdu_sign_fix #(.W(WIDTH)) u_fix_quot (
    .neg(neg_res_q), .in_val(work_q[WIDTH-1:0]), .out_val(quot_fixed));
  // Remainder follows the dividend's sign.
  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
    .neg(neg_rem_q), .in_val(work_q[2*WIDTH-1:WIDTH]), .out_val(rem_fixed));

  // ---------------- controller ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = CALC;
      CALC: begin
        if (flush_i)                  state_d = IDLE;
        else if (count_q == '0)       state_d = FIXUP;
      end
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath and HI/LO ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q    <= '0;
      work_q     <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // MTHI/MTLO land regardless of a simultaneous launch.
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (launch) begin
            count_q    <= CNT_W'(WIDTH - 1);
            is_div_q   <= div_op;
            neg_res_q  <= rs_neg ^ rt_neg;
            neg_rem_q  <= rs_neg;
            div_zero_q <= (rt_data_i == '0);
            if (div_op) begin
              work_q <= {{WIDTH{1'b0}}, mag_rs};
              opnd_q <= mag_rt;
            end else begin
              work_q <= {{WIDTH{1'b0}}, mag_rt};
              opnd_q <= mag_rs;
            end
          end
        end
        CALC: begin
          if (!flush_i) begin
            work_q  <= work_step;
            count_q <= count_q - CNT_W'(1);
          end
        end
        FIXUP: begin
          if (!flush_i) begin
            if (is_div_q) begin
              // A zero divisor leaves the dividend magnitude in the remainder,
              // which re-signs to the original rs; only LO needs overriding.
              lo_q <= div_zero_q ? WIDTH'(DIVZERO_LO) : quot_fixed;
              hi_q <= rem_fixed;
            end else begin
              {hi_q, lo_q} <= prod_fixed;
            end
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign stall_o = busy_o | launch;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases with literal results,
// then randomized traffic compared every cycle against a behavioural model.
// The model works from arithmetic results and a cycle countdown only.
module tb_mul_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] rs_data_i = '0;
  logic [31:0] rt_data_i = '0;
  logic        flush_i = 1'b0;
  logic        hi_we_i = 1'b0;
  logic        lo_we_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, done_o, stall_o;

  int total = 0;
  int bad   = 0;

  mul_div_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .flush_i(flush_i),
    .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic void ref_result(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      default: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  int          m_left = 0;     // edges until the pending result lands
  logic        m_done = 1'b0;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (flush_i) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin m_hi = r_hi; m_lo = r_lo; m_done = 1'b1; end
        end
      end else begin
        if (hi_we_i) m_hi = wdata_i;
        if (lo_we_i) m_lo = wdata_i;
        if (start_i && !flush_i) begin
          ref_result(op_i, rs_data_i, rt_data_i, r_hi, r_lo);
          m_left = 33;
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk_i) begin
    chk("hi", hi_o, m_hi);
    chk("lo", lo_o, m_lo);
    chk("busy", 32'(busy_o), 32'(m_left > 0));
    chk("done", 32'(done_o), 32'(m_done));
    chk("stall", 32'(stall_o), 32'((m_left > 0) || (start_i && !flush_i)));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy_o && g < 100) begin tick(); g++; end
    if (g >= 100) chk("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; rs_data_i = a; rt_data_i = b; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Returns the edge number (accept = 1) at which done_o became visible.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done_o && lat < 60) begin tick(); lat++; end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    wait_idle();
    start_op(op, a, b);
    wait_done(lat);
    chk({name, "_lat"}, 32'(lat), 32'd34);
    chk({name, "_hi"}, hi_o, ehi);
    chk({name, "_lo"}, lo_o, elo);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = $urandom_range(0, 20);
      4:       v = 32'(0 - $urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, d1, d2;
    bit  seen_done;

    repeat (3) tick();
    rst_i = 1'b1;
    tick();

    // Arithmetic corner cases.
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    tick();
    chk("done_pulse_width", 32'(done_o), 32'd0);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // Flush at cycle 10 of a DIVU.
    wait_idle();
    start_op(2'b11, 32'd50, 32'd3);
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_hi", hi_o, 32'h0);
    chk("flush_lo", lo_o, 32'h8000_0000);
    seen_done = 1'b0;
    repeat (30) begin tick(); if (done_o) seen_done = 1'b1; end
    chk("flush_no_done", 32'(seen_done), 32'd0);

    // MTLO accepted when idle, dropped while busy.
    lo_we_i = 1'b1; wdata_i = 32'h1234;
    tick();
    lo_we_i = 1'b0;
    chk("mtlo_idle", lo_o, 32'h1234);
    start_op(2'b01, 32'd2, 32'd3);
    repeat (4) tick();
    lo_we_i = 1'b1; wdata_i = 32'h5678;
    tick();
    lo_we_i = 1'b0;
    chk("mtlo_busy", lo_o, 32'h1234);
    wait_done(lat);
    chk("mtlo_op_lo", lo_o, 32'd6);

    // Reset in the middle of a MULT.
    wait_idle();
    start_op(2'b00, 32'd5, 32'd6);
    repeat (19) tick();
    rst_i = 1'b0;
    #1;
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    tick();
    rst_i = 1'b1;
    tick();

    // start_i held high across two operations.
    op_i = 2'b11; rs_data_i = 32'd1000; rt_data_i = 32'd7; start_i = 1'b1;
    tick();
    lat = 1; d1 = 0; d2 = 0;
    while (d2 == 0 && lat < 80) begin
      if (done_o) begin
        if (d1 == 0) d1 = lat;
        else d2 = lat;
      end
      if (d2 == 0) begin tick(); lat++; end
    end
    start_i = 1'b0;
    chk("b2b_first", 32'(d1), 32'd34);
    chk("b2b_second", 32'(d2), 32'd68);
    chk("b2b_lo", lo_o, 32'd142);
    chk("b2b_hi", hi_o, 32'd6);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 4000; i++) begin
      start_i   = ($urandom_range(0, 3) == 0);
      op_i      = 2'($urandom_range(0, 3));
      rs_data_i = pick();
      rt_data_i = pick();
      flush_i   = ($urandom_range(0, 39) == 0);
      hi_we_i   = ($urandom_range(0, 9) == 0);
      lo_we_i   = ($urandom_range(0, 9) == 0);
      wdata_i   = $urandom;
      tick();
    end
    start_i = 1'b0; flush_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    wait_idle();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
